if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the decode stage. Owns the program counter and issues fetches to instruction memory over a req/ack handshake, one request outstanding. Handles branch redirect (flush) from the execute path and freeze from the hazard unit. Presents PC+4, instruction and valid to decode.

Parameters:
ADDR_W, 32, address / PC width
INSTR_W, 32, instruction width
RESET_PC, 0, first fetch address after reset
NOP_INSTR, 0, instruction value driven on bubble/flush

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low (asserted when 0)
freeze  in  1  hazard stall; IF/ID register holds
branch_taken  in  1  redirect request; flushes IF/ID
branch_addr  in  ADDR_W  redirect target
imem_req  out  1  fetch request
imem_addr  out  ADDR_W  fetch address, stable while imem_req=1
imem_ack  in  1  data valid this cycle; ignored when imem_req=0
imem_rdata  in  INSTR_W  fetched instruction
PC  out  ADDR_W  fetched address + 4
instruction_out  out  INSTR_W  fetched instruction
valid_out  out  1  instruction_out is a real instruction

Behaviour:
- Registers: pc (next address to fetch), fetch_addr (drives imem_addr), skid buffer {addr+4, instr}, IF/ID {PC, instruction_out, valid_out}, state.
- Reset (rst=0, async): state=IDLE, pc=fetch_addr=RESET_PC, imem_req=0, PC=0, instruction_out=NOP_INSTR, valid_out=0, buffer cleared.
- imem_req = 1 in FETCH and DRAIN, 0 otherwise. Ack may arrive in the same cycle as req: 1 instruction/cycle throughput, IF/ID updated on that edge.
- Bubble: in any non-frozen cycle that does not load a real instruction, IF/ID <= {0, NOP_INSTR, 0}.
- Priority per edge: branch_taken > freeze > ack.
- IDLE: next state FETCH, fetch_addr=pc.
- FETCH:
  - branch_taken: IF/ID flushed (bubble, even if freeze=1); pc <= branch_addr. With ack: data discarded, fetch_addr <= branch_addr, stay FETCH. Without ack: go DRAIN, fetch_addr unchanged.
  - ack, !freeze: IF/ID <= {fetch_addr+4, imem_rdata, 1}; pc, fetch_addr <= fetch_addr+4; stay FETCH.
  - ack, freeze: IF/ID held; buffer <= {fetch_addr+4, imem_rdata}; pc <= fetch_addr+4; go HOLD.
  - no ack: IF/ID bubble if !freeze, held if freeze.
- DRAIN (finishing an abandoned request): ack -> data discarded, fetch_addr <= pc, go FETCH. branch_taken again -> pc <= new branch_addr, stay DRAIN; if with ack, fetch_addr <= new branch_addr, go FETCH.
- HOLD (imem_req=0): freeze=1 -> all held. freeze=0 -> IF/ID <= {buffer, 1}; fetch_addr <= pc; go FETCH. branch_taken -> IF/ID and buffer flushed, pc=fetch_addr <= branch_addr, go FETCH.
- Address arithmetic is modulo 2^ADDR_W: 0xFFFFFFFC + 4 wraps to 0.
- rst asserted mid-transaction drops imem_req immediately. Memory must discard the pending request.

Optional Feature:
IF_PERF_CNT_EN: when defined, adds outputs fetch_count[31:0] (increments on each ack accepted into IF/ID or buffer, excluding discarded ones) and stall_count[31:0] (increments each cycle freeze=1 and branch_taken=0). Both wrap and reset to 0. When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Release reset, imem_ack tied 1, rdata=addr^0xA5A5A5A5 -> imem_addr 0,4,8,... from cycle 2. PC=4,8,12 with valid_out=1 every cycle after the first fetch.
- Ack on every 3rd cycle -> valid_out=1 only on ack edges, NOP_INSTR/valid_out=0 otherwise, imem_addr stable while waiting.
- freeze=1 for 3 cycles during an ack at addr 0x10 -> IF/ID holds prior entry, imem_req=0 in HOLD. After release: PC=0x14, rdata presented, next fetch addr 0x14.
- branch_taken with branch_addr=0x100 while a request to 0x20 is pending (no ack) -> DRAIN. The 0x20 ack data never reaches valid_out. Next request addr 0x100, then PC=0x104.
- branch_taken and freeze in the same cycle -> valid_out=0 next cycle, fetch redirects to target.
- pc=0xFFFFFFFC with ack -> PC=0x00000000, next imem_addr=0.

Source files
------------

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory fetch channel: one request outstanding, ack may land in the request cycle.
interface if_fetch_stage_if #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned INSTR_W = 32
);
  logic               req;
  logic [ADDR_W-1:0]  addr;
  logic               ack;
  logic [INSTR_W-1:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage with IF/ID register, branch redirect, freeze skid buffer.
// Define IF_PERF_CNT_EN to add the fetch_count / stall_count performance outputs.
module if_fetch_stage #(
  parameter int unsigned        ADDR_W    = 32,
  parameter int unsigned        INSTR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                freeze,
  input  logic                branch_taken,
  input  logic [ADDR_W-1:0]   branch_addr,
  if_fetch_stage_if.master    imem,
  output logic [ADDR_W-1:0]   PC,
  output logic [INSTR_W-1:0]  instruction_out,
  output logic                valid_out
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]         fetch_count,
  output logic [31:0]         stall_count
`endif
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HOLD} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  state_t             state;
  logic               req_q;
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  fetch_addr;
  logic [ADDR_W-1:0]  seq_addr_c;
  entry_t             skid;
  logic               accept_c;
  logic               ifid_hold_c;
  logic               ifid_load_mem_c;
  logic               ifid_load_buf_c;

  assign imem.req   = req_q;
  assign imem.addr  = fetch_addr;
  assign seq_addr_c = fetch_addr + ADDR_W'(4);
  // A returned instruction is kept (IF/ID or skid) only in FETCH without a redirect.
  assign accept_c   = (state == FETCH) && imem.ack && !branch_taken;

  // IF/ID update selection: branch flush beats freeze, freeze beats any load.
  always_comb begin
    ifid_hold_c     = 1'b0;
    ifid_load_mem_c = 1'b0;
    ifid_load_buf_c = 1'b0;
    if (!branch_taken) begin
      if (freeze)
        ifid_hold_c = 1'b1;
      else if (accept_c)
        ifid_load_mem_c = 1'b1;
      else if (state == HOLD)
        ifid_load_buf_c = 1'b1;
    end
  end

  // Fetch control: state, request, pc, fetch address and skid buffer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      req_q      <= 1'b0;
      pc         <= RESET_PC;
      fetch_addr <= RESET_PC;
      skid       <= '0;
    end else begin
      case (state)
        IDLE: begin
          state <= FETCH;
          req_q <= 1'b1;
          if (branch_taken) begin
            pc         <= branch_addr;
            fetch_addr <= branch_addr;
          end else begin
            fetch_addr <= pc;
          end
        end
        FETCH: begin
          if (branch_taken) begin
            pc <= branch_addr;
            if (imem.ack)
              fetch_addr <= branch_addr;
            else
              state <= DRAIN;
          end else if (imem.ack) begin
            pc <= seq_addr_c;
            if (freeze) begin
              skid  <= '{pc: seq_addr_c, instr: imem.rdata};
              state <= HOLD;
              req_q <= 1'b0;
            end else begin
              fetch_addr <= seq_addr_c;
            end
          end
        end
        DRAIN: begin
          // The abandoned request must complete before the redirected fetch starts.
          if (branch_taken) begin
            pc <= branch_addr;
            if (imem.ack) begin
              fetch_addr <= branch_addr;
              state      <= FETCH;
            end
          end else if (imem.ack) begin
            fetch_addr <= pc;
            state      <= FETCH;
          end
        end
        HOLD: begin
          if (branch_taken) begin
            skid       <= '0;
            pc         <= branch_addr;
            fetch_addr <= branch_addr;
            state      <= FETCH;
            req_q      <= 1'b1;
          end else if (!freeze) begin
            fetch_addr <= pc;
            state      <= FETCH;
            req_q      <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          req_q <= 1'b0;
        end
      endcase
    end
  end

  // IF/ID pipeline register; anything not loaded or held becomes a bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      PC              <= '0;
      instruction_out <= NOP_INSTR;
      valid_out       <= 1'b0;
    end else if (ifid_hold_c) begin
      PC              <= PC;
      instruction_out <= instruction_out;
      valid_out       <= valid_out;
    end else if (ifid_load_mem_c) begin
      PC              <= seq_addr_c;
      instruction_out <= imem.rdata;
      valid_out       <= 1'b1;
    end else if (ifid_load_buf_c) begin
      PC              <= skid.pc;
      instruction_out <= skid.instr;
      valid_out       <= 1'b1;
    end else begin
      PC              <= '0;
      instruction_out <= NOP_INSTR;
      valid_out       <= 1'b0;
    end
  end

`ifdef IF_PERF_CNT_EN
  // Wrapping event counters: kept fetches and frozen (non-redirect) cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (accept_c)
        fetch_count <= fetch_count + 32'd1;
      if (freeze && !branch_taken)
        stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: program-stream reference model, directed plus random stimulus.
module tb_if_fetch_stage;
  localparam logic [31:0] K       = 32'hA5A5_A5A5;
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [64:0] BUBBLE  = {32'h0, NOP, 1'b0};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = '0;
  logic [31:0] PC;
  logic [31:0] instruction_out;
  logic        valid_out;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  if_fetch_stage_if #(.ADDR_W(32), .INSTR_W(32)) imem();

  if_fetch_stage #(
    .ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h0), .NOP_INSTR(NOP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .freeze(freeze),
    .branch_taken(branch_taken),
    .branch_addr(branch_addr),
    .imem(imem),
    .PC(PC),
    .instruction_out(instruction_out),
    .valid_out(valid_out)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_count(fetch_count),
    .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [64:0] exp_q[$];
  logic [63:0] pend_q[$];
  logic [64:0] last_out = BUBBLE;
  logic [31:0] stream = 32'h0;
  bit          abandoned = 1'b0;
  bit          prev_req = 1'b0;
  bit          prev_ack = 1'b0;
  logic [31:0] prev_addr = '0;
  bit          expect_req_low = 1'b0;

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // One clock of stimulus; the model predicts the IF/ID contents after the coming edge.
  task automatic cycle(input bit a, input bit f, input bit b, input logic [31:0] ba);
    bit          acc;
    logic [64:0] out;
    @(negedge clk);
    if (prev_req && !prev_ack)
      check("addr_stable", {32'h0, imem.req, imem.addr}, {32'h0, 1'b1, prev_addr});
    if (expect_req_low)
      check("hold_req_low", 65'(imem.req), 65'(0));
    imem.ack     = a;
    imem.rdata   = imem.addr ^ K;
    freeze       = f;
    branch_taken = b;
    branch_addr  = ba;
    acc = imem.req && a && !b && !abandoned;
    if (acc) begin
      check("fetch_addr", 65'(imem.addr), 65'(stream));
      pend_q.push_back({stream + 32'd4, stream ^ K});
      stream = stream + 32'd4;
    end
    if (b) begin
      pend_q.delete();
      stream = ba;
      out = BUBBLE;
    end else if (f) begin
      out = last_out;
    end else if (pend_q.size() != 0) begin
      out = {pend_q.pop_front(), 1'b1};
    end else begin
      out = BUBBLE;
    end
    if (imem.req && a) abandoned = 1'b0;
    else if (imem.req && b) abandoned = 1'b1;
    expect_req_low = acc && f;
    prev_req  = imem.req;
    prev_ack  = a;
    prev_addr = imem.addr;
    last_out  = out;
    exp_q.push_back(out);
  endtask

  // Monitor: compare IF/ID against the oldest prediction after every edge.
  initial begin : monitor
    logic [64:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("ifid", {PC, instruction_out, valid_out}, e);
      end
    end
  end

  initial begin : stim
    logic [31:0] ba;
    imem.ack   = 1'b0;
    imem.rdata = '0;
    repeat (2) @(negedge clk);
    check("reset_ifid", {PC, instruction_out, valid_out}, BUBBLE);
    check("reset_req", {32'h0, imem.req, imem.addr}, 65'h0);
    #2 rst = 1'b1;

    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 9; i++) cycle(i % 3 == 2, 1'b0, 1'b0, 32'h0);

    // Freeze over an ack at 0x10, then release.
    cycle(1'b1, 1'b0, 1'b1, 32'h10);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);

    // Redirect to 0x100 while the 0x20 request is outstanding.
    cycle(1'b1, 1'b0, 1'b1, 32'h20);
    cycle(1'b0, 1'b0, 1'b1, 32'h100);
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);

    // Branch together with freeze.
    cycle(1'b1, 1'b1, 1'b1, 32'h200);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);

    // Address wrap at the top of memory.
    cycle(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);

    for (int i = 0; i < 3000; i++) begin
      ba = $urandom() & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) ba = 32'hFFFF_FFF8;
      cycle($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 2,
            $urandom_range(0, 99) < 7, ba);
    end

    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #2;
    check("scoreboard_empty", 65'(exp_q.size()), 65'(0));

    // Asynchronous reset in the middle of a request.
    rst = 1'b0;
    #1;
    check("async_rst_req", {32'h0, imem.req, imem.addr}, 65'h0);
    check("async_rst_ifid", {PC, instruction_out, valid_out}, BUBBLE);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
